uart_ctrl: RTL
==============

Name: uart_ctrl

Overview:
- Memory-mapped controller that sequences the 8-bit UART datapath (115200 bps at 50 MHz) for the 8-bit CPU.
- CPU writes bytes into a TX FIFO; an FSM feeds them one at a time to the UART transmitter via `begin_flag`/`busy_flag`.
- Received bytes, flagged by `receive_flag`, are buffered in an RX FIFO.
- Sits between the CPU I/O bus and the UART; provides status and an interrupt.

Parameters:
- FIFO_DEPTH, 4, entries per TX and RX FIFO; power of two, ≥2
- BUSY_TIMEOUT, 16, cycles to wait for `busy_flag` to rise after `begin_flag` before abandoning the byte

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-high reset
- cs  input  1  bus select
- we  input  1  1=write, 0=read (qualified by cs)
- addr  input  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
- wdata  input  8  write data
- rdata  output  8  registered read data
- irq  output  1  level interrupt
- uart_tx_en  output  1  UART transmitter enable
- uart_rx_en  output  1  UART receiver enable
- uart_begin_flag  output  1  one-cycle start-transmit pulse
- uart_tx_data  output  8  byte to transmit, held stable from begin until done
- uart_busy_flag  input  1  UART transmitter busy
- uart_rx_data  input  8  received byte
- uart_receive_flag  input  1  receive-complete flag, level or pulse

Behaviour:
- Reset, asynchronous, active-high. Outputs and state:
  - rdata=0x00, irq=0, uart_begin_flag=0, uart_tx_data=0x00.
  - CTRL=0x00, so uart_tx_en=uart_rx_en=0.
  - Both FIFOs empty, overrun=0, FSM=IDLE.
- Reset mid-transmission: the in-flight byte and all queued bytes are discarded.
- Bus accesses act on the clk edge where cs=1. Read data appears on rdata the following cycle and holds until the next read. Reads of addr 3 return 0x00; writes to addr 3 are ignored.
- DATA write:
  - Pushes wdata into TX FIFO.
  - If TX FIFO is full and not popped that same cycle, the byte is dropped.
- DATA read:
  - Returns the RX FIFO head and pops it.
  - If RX FIFO is empty: returns 0x00, no pop.
- STATUS read: bit0 tx_full, bit1 tx_empty, bit2 rx_valid (RX not empty), bit3 rx_overrun, bit4 tx_idle (FSM=IDLE and TX FIFO empty), bits7:5=0.
- STATUS write with wdata[3]=1 clears overrun. If an overrun occurs in the same cycle, set wins.
- CTRL (read/write):
  - bit0 tx_enable, drives uart_tx_en.
  - bit1 rx_enable, drives uart_rx_en.
  - bit2 rx_irq_en, bit3 txe_irq_en.
  - bit4 per Optional Feature; otherwise reads 0.
  - bits7:5 read 0.
- irq = (rx_irq_en & (rx_valid | overrun)) | (txe_irq_en & tx_idle).
- TX FSM:
  - IDLE:
    - If tx_enable and TX FIFO not empty: pop head into uart_tx_data, go to START.
  - START:
    - uart_begin_flag=1 for exactly this cycle, then go to WAIT_BUSY; clear timeout counter.
  - WAIT_BUSY:
    - busy_flag=1: go to WAIT_DONE.
    - Counter reaches BUSY_TIMEOUT-1: go to IDLE; byte is lost.
  - WAIT_DONE:
    - busy_flag=0: go to IDLE.
  - Minimum of 1 idle cycle between consecutive begin pulses.
  - Clearing tx_enable mid-byte: the current byte completes; no new byte is started.
- RX path:
  - receive_flag is edge-detected (rising edge only, registered previous value), so a level flag pushes exactly one byte.
  - Pushes are taken only when rx_enable=1.
  - Push when RX FIFO full and no same-cycle pop: byte dropped, overrun=1.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overrun.
- FIFOs: circular, pointers wrap modulo FIFO_DEPTH, count width clog2(FIFO_DEPTH)+1. Empty pop is a no-op; full push follows the rules above.

Optional Feature:
- Macro: UART_CTRL_LOOPBACK_EN.
- Defined:
  - CTRL bit4 = loopback, read/write.
  - When loopback=1, the TX FSM does not drive the UART: uart_begin_flag stays 0.
  - Each byte popped in IDLE is pushed directly into the RX FIFO on the next cycle (START), using the same full/overrun rules, then returns to IDLE.
  - rx_enable is ignored for loopback pushes.
- Undefined:
  - CTRL bit4 write ignored, reads 0.
  - No loopback path is synthesized.

Test Plan:
- Reset then read STATUS → 0x12 (tx_empty, tx_idle); CTRL → 0x00; irq=0.
- CTRL=0x01; write DATA 0x55, 0xAA; model busy_flag high 3 cycles after each begin.
  - → two single-cycle begin pulses with uart_tx_data 0x55 then 0xAA.
  - → STATUS bit4 returns 1 after the second busy falls.
- CTRL=0x02; deliver 5 receive_flag edges with bytes 0x01..0x05 (FIFO_DEPTH=4).
  - → DATA reads return 0x01..0x04, fifth read returns 0x00.
  - → STATUS bit3=1; write STATUS 0x08 clears it.
- CTRL=0x01; busy_flag held 0; write 0x33.
  - → one begin pulse, FSM returns to IDLE after 16 cycles, tx_idle=1.
- CTRL=0x06, receive 0x7E → irq=1; read DATA=0x7E → irq=0 next cycle.
- Loopback (macro defined): CTRL=0x10; write 0x5A.
  - → no begin pulse; DATA read returns 0x5A.

Source files
------------

// File: rtl/uart_ctrl.sv
// uart_ctrl: CPU-side controller for an 8-bit UART datapath.
// Holds TX/RX FIFOs, a TX sequencing FSM, status/control registers and irq.
// Optional loopback path: define UART_CTRL_LOOPBACK_EN to build it.
// Ports:
//   clk, rst             clock, async active-high reset
//   cs, we, addr, wdata  CPU bus (addr 0 DATA, 1 STATUS, 2 CTRL, 3 reserved)
//   rdata                registered read data, irq level interrupt
//   uart_tx_en/rx_en     UART enables from CTRL
//   uart_begin_flag      one-cycle start pulse, uart_tx_data held byte
//   uart_busy_flag       transmitter busy
//   uart_rx_data         received byte, uart_receive_flag completion flag
module uart_ctrl #(
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq,
    output logic       uart_tx_en,
    output logic       uart_rx_en,
    output logic       uart_begin_flag,
    output logic [7:0] uart_tx_data,
    input  logic       uart_busy_flag,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_receive_flag
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t state, state_nx;

    logic [3:0]    ctrl;
    logic          loopback;
    logic          overrun;
    logic [TW-1:0] tcnt;

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr;
    logic [AW:0]   tx_cnt;
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wptr, rx_rptr;
    logic [AW:0]   rx_cnt;

    logic rx_flag_q;
    logic tx_full, tx_empty, rx_full, rx_empty, tx_idle;
    logic tx_go, tx_pop, tx_push;
    logic lb_push, rx_push_req, rx_push, rx_pop, ovr_set;
    logic wr_data, rd_data, wr_stat, wr_ctrl, rd;
    logic [7:0] rx_wdata, status;

    assign wr_data = cs & we & (addr == 2'd0);
    assign rd_data = cs & ~we & (addr == 2'd0);
    assign wr_stat = cs & we & (addr == 2'd1);
    assign wr_ctrl = cs & we & (addr == 2'd2);
    assign rd      = cs & ~we;

    assign tx_full  = (tx_cnt == (AW+1)'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == (AW+1)'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt == '0);
    assign tx_idle  = (state == IDLE) & tx_empty;

    assign status = {3'b000, tx_idle, overrun, ~rx_empty, tx_empty, tx_full};

    assign uart_tx_en = ctrl[0];
    assign uart_rx_en = ctrl[1];
    assign irq = (ctrl[2] & (~rx_empty | overrun)) | (ctrl[3] & tx_idle);

`ifdef UART_CTRL_LOOPBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            loopback <= 1'b0;
        else if (wr_ctrl)
            loopback <= wdata[4];
    end
    assign lb_push = loopback & (state == START);
`else
    assign loopback = 1'b0;
    assign lb_push  = 1'b0;
`endif

    // Loopback drains the TX FIFO even with tx_enable clear, since no
    // UART transfer is involved.
    assign tx_go   = (ctrl[0] | loopback) & ~tx_empty;
    assign tx_push = wr_data & (~tx_full | tx_pop);

    assign rx_pop      = rd_data & ~rx_empty;
    assign rx_push_req = lb_push | (uart_receive_flag & ~rx_flag_q & ctrl[1]);
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);
    assign ovr_set     = rx_push_req & rx_full & ~rx_pop;
    assign rx_wdata    = lb_push ? uart_tx_data : uart_rx_data;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (tx_go) state_nx = START;
            START:     state_nx = loopback ? IDLE : WAIT_BUSY;
            WAIT_BUSY: begin
                if (uart_busy_flag)
                    state_nx = WAIT_DONE;
                else if (tcnt == TW'(BUSY_TIMEOUT - 1))
                    state_nx = IDLE;
            end
            WAIT_DONE: if (!uart_busy_flag) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        tx_pop          = 1'b0;
        uart_begin_flag = 1'b0;
        unique case (state)
            IDLE:    tx_pop = tx_go;
            START:   uart_begin_flag = ~loopback;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tcnt <= '0;
        else if (state == START)
            tcnt <= '0;
        else if (state == WAIT_BUSY)
            tcnt <= tcnt + TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl         <= '0;
            overrun      <= 1'b0;
            rx_flag_q    <= 1'b0;
            uart_tx_data <= '0;
            rdata        <= '0;
        end else begin
            rx_flag_q <= uart_receive_flag;
            if (wr_ctrl)
                ctrl <= wdata[3:0];
            if (ovr_set)
                overrun <= 1'b1;
            else if (wr_stat && wdata[3])
                overrun <= 1'b0;
            if (tx_pop)
                uart_tx_data <= tx_mem[tx_rptr];
            if (rd) begin
                unique case (addr)
                    2'd0: rdata <= rx_empty ? 8'h00 : rx_mem[rx_rptr];
                    2'd1: rdata <= status;
                    2'd2: rdata <= {3'b000, loopback, ctrl};
                    default: rdata <= 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wptr] <= wdata;
        if (rx_push)
            rx_mem[rx_wptr] <= rx_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
            if (tx_push && !tx_pop)
                tx_cnt <= tx_cnt + (AW+1)'(1);
            else if (tx_pop && !tx_push)
                tx_cnt <= tx_cnt - (AW+1)'(1);
            if (rx_push) rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
            if (rx_push && !rx_pop)
                rx_cnt <= rx_cnt + (AW+1)'(1);
            else if (rx_pop && !rx_push)
                rx_cnt <= rx_cnt - (AW+1)'(1);
        end
    end

endmodule
